// File: rtl/zigzag_rle_encoder_pkg.sv
// Shared widths, FSM state type and the zigzag scan tables for the
// 8x8 block encoder and any block that walks coefficients in zigzag order.
package zigzag_rle_encoder_pkg;

    localparam int HDATA_BIT      = 12;
    localparam int RUN_BIT        = 6;
    localparam int BLOCK_BIT      = 3;
    localparam int BLOCK_AREA_BIT = 6;
    localparam int BLOCK_AREA     = 64;

    typedef enum logic {
        S_YAZ = 1'b0,   // collecting coefficients
        S_OKU = 1'b1    // scanning and emitting (run, value) pairs
    } enc_state_e;

    // Forward table: zigzag index -> raster address {row, col}.
    localparam logic [BLOCK_AREA_BIT-1:0] ZZ_TABLE [BLOCK_AREA] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    // Inverse table: raster address {row, col} -> zigzag index.
    localparam logic [BLOCK_AREA_BIT-1:0] IZZ_TABLE [BLOCK_AREA] = '{
         0,  1,  5,  6, 14, 15, 27, 28,
         2,  4,  7, 13, 16, 26, 29, 42,
         3,  8, 12, 17, 25, 30, 41, 43,
         9, 11, 18, 24, 31, 40, 44, 53,
        10, 19, 23, 32, 39, 45, 52, 54,
        20, 22, 33, 38, 46, 51, 55, 60,
        21, 34, 37, 47, 50, 56, 59, 61,
        35, 36, 48, 49, 57, 58, 62, 63
    };

endpackage

// File: rtl/zigzag_rle_encoder_zigzag_rom.sv
// Combinational dual zigzag lookup: zigzag index -> raster address and
// raster address -> zigzag index. Usable by the normalizer as well.
module zigzag_rom
    import zigzag_rle_encoder_pkg::*;
(
    input  logic [BLOCK_AREA_BIT-1:0] i_zz_idx,
    output logic [BLOCK_AREA_BIT-1:0] o_raster,
    input  logic [BLOCK_AREA_BIT-1:0] i_raster,
    output logic [BLOCK_AREA_BIT-1:0] o_zz_idx
);

    assign o_raster = ZZ_TABLE[i_zz_idx];
    assign o_zz_idx = IZZ_TABLE[i_raster];

endmodule

// File: rtl/zigzag_rle_encoder.sv
// Zigzag run-length encoder: buffers one 8x8 block of quantized
// coefficients addressed by (row, col), then scans it in zigzag order and
// emits (run, value) pairs, flagging the last nonzero pair of the block.
//
// Handshake (both sides): a beat transfers on a rising edge where
// valid && ready. Once hd_gecerli_o is high, hd_run_o/hd_veri_o/hd_son_o
// hold steady until the edge that transfers them.
module zigzag_rle_encoder
    import zigzag_rle_encoder_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic signed [HDATA_BIT-1:0] ct_veri_i,
    input  logic [BLOCK_BIT-1:0]        ct_row_i,
    input  logic [BLOCK_BIT-1:0]        ct_col_i,
    input  logic                        ct_gecerli_i,
    input  logic                        ct_blok_son_i,
    output logic                        ct_hazir_o,
    output logic [RUN_BIT-1:0]          hd_run_o,
    output logic signed [HDATA_BIT-1:0] hd_veri_o,
    output logic                        hd_gecerli_o,
    output logic                        hd_son_o,
    input  logic                        hd_hazir_i,
    output enc_state_e                  o_dbg_state
);

    enc_state_e                  r_state;
    enc_state_e                  w_next_state;

    logic [HDATA_BIT-1:0]        r_buf [BLOCK_AREA];
    logic [BLOCK_AREA-1:0]       r_written;   // raster-indexed: entry holds a value
    logic [BLOCK_AREA-1:0]       r_nz_zz;     // zigzag-indexed: entry is nonzero
    logic [BLOCK_AREA_BIT-1:0]   r_zz;
    logic [RUN_BIT-1:0]          r_run;

    logic [RUN_BIT-1:0]          r_out_run;
    logic signed [HDATA_BIT-1:0] r_out_veri;
    logic                        r_out_valid;
    logic                        r_out_son;

    logic [BLOCK_AREA_BIT-1:0]   w_wr_addr;
    logic [BLOCK_AREA_BIT-1:0]   w_wr_zz;
    logic [BLOCK_AREA_BIT-1:0]   w_rd_addr;
    logic [BLOCK_AREA_BIT-1:0]   w_last_nz;
    logic signed [HDATA_BIT-1:0] w_coef;
    logic                        w_accept;
    logic                        w_emit_cond;
    logic                        w_slot_free;
    logic                        w_load;
    logic                        w_son;

    assign w_wr_addr = {ct_row_i, ct_col_i};

    zigzag_rom u_rom (
        .i_zz_idx (r_zz),
        .o_raster (w_rd_addr),
        .i_raster (w_wr_addr),
        .o_zz_idx (w_wr_zz)
    );

    assign w_accept    = (r_state == S_YAZ) && ct_gecerli_i;
    assign w_coef      = r_written[w_rd_addr] ? r_buf[w_rd_addr] : '0;
    assign w_emit_cond = (r_zz == '0) || (w_coef != '0);
    assign w_slot_free = !r_out_valid || hd_hazir_i;
    assign w_load      = (r_state == S_OKU) && w_emit_cond && w_slot_free;
    assign w_son       = (r_zz == w_last_nz);

    // Highest zigzag index holding a nonzero value; kept as a live mask so a
    // later zero write to a position withdraws it from the end-of-block mark.
    always_comb begin
        w_last_nz = '0;
        for (int i = 0; i < BLOCK_AREA; i++) begin
            if (r_nz_zz[i]) w_last_nz = BLOCK_AREA_BIT'(i);
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_YAZ;
        else       r_state <= w_next_state;
    end

    // Next state: leave YAZ on the accepted last beat, leave OKU on the son pair.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_YAZ:   if (w_accept && ct_blok_son_i) w_next_state = S_OKU;
            S_OKU:   if (w_load && w_son)           w_next_state = S_YAZ;
            default: w_next_state = S_YAZ;
        endcase
    end

    // Coefficient storage; stale contents are masked by r_written.
    always_ff @(posedge clk_i) begin
        if (w_accept) r_buf[w_wr_addr] <= ct_veri_i;
    end

    // Masks, scan pointer/run counter and the output register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_written   <= '0;
            r_nz_zz     <= '0;
            r_zz        <= '0;
            r_run       <= '0;
            r_out_run   <= '0;
            r_out_veri  <= '0;
            r_out_valid <= 1'b0;
            r_out_son   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_written[w_wr_addr] <= 1'b1;
                r_nz_zz[w_wr_zz]     <= (ct_veri_i != '0);
                if (ct_blok_son_i) begin
                    r_zz  <= '0;
                    r_run <= '0;
                end
            end

            if (r_state == S_OKU) begin
                if (!w_emit_cond) begin
                    r_run <= r_run + RUN_BIT'(1);
                    r_zz  <= r_zz + BLOCK_AREA_BIT'(1);
                end else if (w_slot_free) begin
                    r_run <= '0;
                    r_zz  <= r_zz + BLOCK_AREA_BIT'(1);
                    if (w_son) begin
                        r_written <= '0;
                        r_nz_zz   <= '0;
                    end
                end
            end

            if (w_load) begin
                r_out_run   <= r_run;
                r_out_veri  <= w_coef;
                r_out_son   <= w_son;
                r_out_valid <= 1'b1;
            end else if (hd_hazir_i) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign ct_hazir_o   = (r_state == S_YAZ);
    assign hd_run_o     = r_out_run;
    assign hd_veri_o    = r_out_veri;
    assign hd_gecerli_o = r_out_valid;
    assign hd_son_o     = r_out_son;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_zigzag_rle_encoder.sv
// Directed bench for zigzag_rle_encoder: blocks are written beat by beat,
// emitted pairs are collected and compared against hand-derived sequences.
module tb_zigzag_rle_encoder;
    import zigzag_rle_encoder_pkg::*;

    localparam int PW = 1 + RUN_BIT + HDATA_BIT;

    // clock / reset
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    logic signed [HDATA_BIT-1:0] ct_veri_i = '0;
    logic [BLOCK_BIT-1:0]        ct_row_i = '0;
    logic [BLOCK_BIT-1:0]        ct_col_i = '0;
    logic                        ct_gecerli_i = 1'b0;
    logic                        ct_blok_son_i = 1'b0;
    logic                        ct_hazir_o;
    logic [RUN_BIT-1:0]          hd_run_o;
    logic signed [HDATA_BIT-1:0] hd_veri_o;
    logic                        hd_gecerli_o;
    logic                        hd_son_o;
    logic                        hd_hazir_i = 1'b1;
    enc_state_e                  o_dbg_state;

    zigzag_rle_encoder dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .ct_veri_i     (ct_veri_i),
        .ct_row_i      (ct_row_i),
        .ct_col_i      (ct_col_i),
        .ct_gecerli_i  (ct_gecerli_i),
        .ct_blok_son_i (ct_blok_son_i),
        .ct_hazir_o    (ct_hazir_o),
        .hd_run_o      (hd_run_o),
        .hd_veri_o     (hd_veri_o),
        .hd_gecerli_o  (hd_gecerli_o),
        .hd_son_o      (hd_son_o),
        .hd_hazir_i    (hd_hazir_i),
        .o_dbg_state   (o_dbg_state)
    );

    // scoreboard
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] got_q[$];
    int checks = 0;
    int errors = 0;

    // Inputs change 1 time unit after a rising edge, so at the falling edge
    // valid && ready means the pair transfers on the next rising edge.
    always @(negedge clk_i) begin
        if (!rst_i && hd_gecerli_o && hd_hazir_i)
            got_q.push_back({hd_son_o, hd_run_o, hd_veri_o});
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [PW-1:0] mk(input logic s, input int r, input int v);
        logic [RUN_BIT-1:0]   rr;
        logic [HDATA_BIT-1:0] vv;
        rr = RUN_BIT'(r);
        vv = HDATA_BIT'(v);
        return {s, rr, vv};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // driver
    task automatic send(input int row, input int col, input int val, input logic son);
        ct_row_i      = BLOCK_BIT'(row);
        ct_col_i      = BLOCK_BIT'(col);
        ct_veri_i     = HDATA_BIT'(val);
        ct_blok_son_i = son;
        ct_gecerli_i  = 1'b1;
        tick();
        ct_gecerli_i  = 1'b0;
        ct_blok_son_i = 1'b0;
        ct_veri_i     = '0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((o_dbg_state != S_YAZ || hd_gecerli_o) && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, 32'(n < 300), 32'd1);
    endtask

    task automatic compare_pairs(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size())
                check($sformatf("%s_pair%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        // reset state
        tick();
        tick();
        check("rst_ct_hazir", 32'(ct_hazir_o), 32'd1);
        check("rst_gecerli",  32'(hd_gecerli_o), 32'd0);
        check("rst_run",      32'(hd_run_o), 32'd0);
        check("rst_veri",     32'(hd_veri_o), 32'd0);
        check("rst_son",      32'(hd_son_o), 32'd0);
        check("rst_state",    32'(o_dbg_state), 32'(S_YAZ));
        rst_i = 1'b0;
        tick();

        // all-zero block: only the son beat
        send(0, 0, 0, 1'b1);
        check("zero_ct_hazir", 32'(ct_hazir_o), 32'd0);
        check("zero_state",    32'(o_dbg_state), 32'(S_OKU));
        exp_q.push_back(mk(1'b1, 0, 0));
        wait_idle("zero");
        compare_pairs("zero");

        // sparse block: DC, zz 2 and zz 63
        send(0, 0, 5, 1'b0);
        send(1, 0, -3, 1'b0);
        send(7, 7, 7, 1'b1);
        exp_q.push_back(mk(1'b0, 0, 5));
        exp_q.push_back(mk(1'b0, 1, -3));
        exp_q.push_back(mk(1'b1, 60, 7));
        wait_idle("sparse");
        compare_pairs("sparse");

        // full raster block of ones, with DC latency
        for (int i = 0; i < 63; i++) send(i / 8, i % 8, 1, 1'b0);
        send(7, 7, 1, 1'b1);
        check("full_dc_not_yet", 32'(hd_gecerli_o), 32'd0);
        tick();
        check("full_dc_valid", 32'(hd_gecerli_o), 32'd1);
        check("full_dc_pair", 32'({hd_son_o, hd_run_o, hd_veri_o}), 32'(mk(1'b0, 0, 1)));
        for (int i = 0; i < 64; i++) exp_q.push_back(mk(i == 63, 0, 1));
        wait_idle("full");
        compare_pairs("full");

        // downstream stall for 5 cycles while the second pair is held
        send(0, 0, 2, 1'b0);
        send(0, 1, 3, 1'b0);
        send(1, 0, 4, 1'b0);
        send(2, 0, -1, 1'b1);
        tick();
        tick();
        hd_hazir_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("stall_valid%0d", i), 32'(hd_gecerli_o), 32'd1);
            check($sformatf("stall_data%0d", i),
                  32'({hd_son_o, hd_run_o, hd_veri_o}), 32'(mk(1'b0, 0, 3)));
            check($sformatf("stall_ct_hazir%0d", i), 32'(ct_hazir_o), 32'd0);
        end
        hd_hazir_i = 1'b1;
        exp_q.push_back(mk(1'b0, 0, 2));
        exp_q.push_back(mk(1'b0, 0, 3));
        exp_q.push_back(mk(1'b0, 0, 4));
        exp_q.push_back(mk(1'b1, 0, -1));
        wait_idle("stall");
        compare_pairs("stall");

        // overwrite with zero removes the position from the block end
        send(0, 1, 4, 1'b0);
        send(0, 1, 0, 1'b0);
        send(0, 0, 9, 1'b1);
        exp_q.push_back(mk(1'b1, 0, 9));
        wait_idle("rewrite");
        compare_pairs("rewrite");

        // reset pulse mid-scan discards the block
        send(0, 0, 1, 1'b0);
        send(7, 7, 2, 1'b1);
        tick();
        tick();
        tick();
        rst_i = 1'b1;
        #1;
        check("midrst_gecerli", 32'(hd_gecerli_o), 32'd0);
        check("midrst_veri",    32'(hd_veri_o), 32'd0);
        check("midrst_ct_hazir", 32'(ct_hazir_o), 32'd1);
        check("midrst_state",   32'(o_dbg_state), 32'(S_YAZ));
        tick();
        rst_i = 1'b0;
        tick();
        got_q.delete();
        exp_q.delete();

        // clean block after reset: DC unwritten, (0,2) is zz 5
        send(0, 2, 6, 1'b1);
        exp_q.push_back(mk(1'b0, 0, 0));
        exp_q.push_back(mk(1'b1, 4, 6));
        wait_idle("after_rst");
        compare_pairs("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
